// File: rtl/w_route_ctrl_pkg.sv
// Shared xbar write-path types: W-routing FSM states, B completion record
// and the slave-select decode helper.
package w_route_ctrl_pkg;

  localparam int XB_ID_WIDTH   = 4;
  localparam int XB_NUM_SLAVES = 2;
  localparam int XB_SEL_WIDTH  = (XB_NUM_SLAVES > 1) ? $clog2(XB_NUM_SLAVES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } w_state_e;

  typedef struct packed {
    logic [XB_ID_WIDTH-1:0]  id;
    logic [XB_SEL_WIDTH-1:0] sel;
    logic                    decerr;
  } b_rec_t;

  // Everything at and above the select LSB. The low bits index the slave;
  // any value past the last slave (including aliases in higher bits) is a
  // decode error.
  function automatic logic [63:0] slave_sel(input logic [63:0] addr,
                                            input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/w_route_ctrl.sv
// Per-master W routing controller: pops the AW FIFO front, steers exactly
// AWLEN+1 W beats to the decoded slave, generates slave WLAST and pushes a
// completion record to the B routing queue.
module w_route_ctrl
  import w_route_ctrl_pkg::*;
#(
  parameter int ID_WIDTH   = XB_ID_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = XB_NUM_SLAVES,
  parameter int SEL_LSB    = 28,
  localparam int SEL_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    fifo_empty,
  output logic                    fifo_pop,
  input  logic [ID_WIDTH-1:0]     front_AWID,
  input  logic [ADDR_WIDTH-1:0]   front_AWADDR,
  input  logic [LEN_WIDTH-1:0]    front_AWLEN,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   S_WDATA,
  output logic [DATA_WIDTH/8-1:0] S_WSTRB,
  output logic                    S_WLAST,
  output logic [NUM_SLAVES-1:0]   S_WVALID,
  input  logic [NUM_SLAVES-1:0]   S_WREADY,
  input  logic                    b_full,
  output logic                    b_push,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [SEL_WIDTH-1:0]    b_sel,
  output logic                    b_decerr,
  output logic                    wlast_err
);

  w_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  decerr_q, decerr_d;
  b_rec_t                rec_q, rec_d;
  logic                  b_push_q, b_push_d;
  logic                  wlast_err_q, wlast_err_d;

  logic                  pop_c, wready_c, swlast_c, hs, is_last;
  logic [NUM_SLAVES-1:0] swvalid_c;
  logic [63:0]           sel_field;

  assign sel_field = slave_sel(64'(front_AWADDR), SEL_LSB);
  assign is_last   = (cnt_q == len_q);

  // Next-state, burst bookkeeping and W steering.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    decerr_d    = decerr_q;
    rec_d       = rec_q;
    b_push_d    = 1'b0;
    wlast_err_d = 1'b0;
    pop_c       = 1'b0;
    wready_c    = 1'b0;
    swlast_c    = 1'b0;
    swvalid_c   = '0;
    hs          = 1'b0;
    case (state_q)
      IDLE: begin
        // b_full only gates the start: a burst pushes one record at most.
        if (!fifo_empty && !b_full) begin
          pop_c    = 1'b1;
          id_d     = front_AWID;
          len_d    = front_AWLEN;
          sel_d    = SEL_WIDTH'(sel_field);
          decerr_d = (sel_field >= 64'(NUM_SLAVES));
          cnt_d    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        swlast_c = is_last;
        if (decerr_q) begin
          wready_c = 1'b1;        // sink beats of an unroutable burst
        end else begin
          wready_c         = S_WREADY[sel_q];
          swvalid_c[sel_q] = WVALID;
        end
        hs = WVALID & wready_c;
        if (hs) begin
          cnt_d       = cnt_q + LEN_WIDTH'(1);
          wlast_err_d = (WLAST != is_last);
          if (is_last) begin
            b_push_d = 1'b1;
            rec_d    = '{id: XB_ID_WIDTH'(id_q), sel: XB_SEL_WIDTH'(sel_q), decerr: decerr_q};
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched burst fields; synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      decerr_q    <= 1'b0;
      rec_q       <= '0;
      b_push_q    <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      decerr_q    <= decerr_d;
      rec_q       <= rec_d;
      b_push_q    <= b_push_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  // Handshake outputs are held low while reset is asserted so no FIFO entry
  // is consumed and no beat is accepted before the reset edge lands.
  assign fifo_pop  = ARESETn & pop_c;
  assign WREADY    = ARESETn & wready_c;
  assign S_WVALID  = ARESETn ? swvalid_c : '0;
  assign S_WLAST   = ARESETn & swlast_c;
  assign S_WDATA   = WDATA;
  assign S_WSTRB   = WSTRB;
  assign b_push    = b_push_q;
  assign b_id      = ID_WIDTH'(rec_q.id);
  assign b_sel     = SEL_WIDTH'(rec_q.sel);
  assign b_decerr  = rec_q.decerr;
  assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_w_route_ctrl.sv
// Scoreboard bench for w_route_ctrl: AW FIFO model, master W driver,
// slave-ready pattern player and a negedge monitor.
module tb_w_route_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        fifo_empty, fifo_pop;
  logic [3:0]  front_AWID;
  logic [31:0] front_AWADDR;
  logic [3:0]  front_AWLEN;
  logic [31:0] WDATA, S_WDATA;
  logic [3:0]  WSTRB, S_WSTRB;
  logic        WLAST, WVALID, WREADY, S_WLAST;
  logic [1:0]  S_WVALID, S_WREADY;
  logic        b_full, b_push, b_sel, b_decerr, wlast_err;
  logic [3:0]  b_id;

  w_route_ctrl dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .front_AWID(front_AWID), .front_AWADDR(front_AWADDR), .front_AWLEN(front_AWLEN),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY), .b_full(b_full), .b_push(b_push), .b_id(b_id), .b_sel(b_sel),
    .b_decerr(b_decerr), .wlast_err(wlast_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } aw_t;
  typedef struct { logic [3:0] id; logic sel; logic derr; } brec_t;
  typedef struct { logic [1:0] v; logic [31:0] d; logic [3:0] s; logic l; } beat_t;

  aw_t   fq[$];
  brec_t eb[$];
  beat_t bq[$];
  logic [1:0] rdy_pat[$];
  logic [1:0] rdy_default = 2'b11;

  int n_chk = 0, n_pass = 0;
  int pop_cnt = 0, werr_cnt = 0;
  logic pop_s = 1'b0;
  logic drv_active = 1'b0, drv_decerr = 1'b0, drv_is_last = 1'b0, drv_sel = 1'b0;
  logic exp_werr_p = 1'b0, exp_bp_p = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void update_front();
    fifo_empty = (fq.size() == 0);
    if (fq.size() != 0) begin
      front_AWID = fq[0].id; front_AWADDR = fq[0].addr; front_AWLEN = fq[0].len;
    end else begin
      front_AWID = '0; front_AWADDR = '0; front_AWLEN = '0;
    end
  endfunction

  // AW FIFO model: pop sampled at negedge, applied just after the edge.
  always @(negedge ACLK) pop_s = fifo_pop;
  always @(posedge ACLK) begin
    #1;
    if (pop_s && fq.size() != 0) begin
      void'(fq.pop_front());
      update_front();
    end
  end

  // Slave ready player: per-cycle pattern, else the default.
  always @(posedge ACLK) begin
    #2;
    if (rdy_pat.size() != 0) S_WREADY = rdy_pat.pop_front();
    else S_WREADY = rdy_default;
  end

  // Monitor: slave beats, W steering, registered b_push / wlast_err.
  always @(negedge ACLK) begin
    logic hs_m;
    beat_t eb_t;
    brec_t r;
    hs_m = WVALID & WREADY;
    if (fifo_pop) pop_cnt++;
    if (wlast_err) werr_cnt++;
    if (exp_werr_p || wlast_err) chk("wlast_err", wlast_err, exp_werr_p);
    exp_werr_p = hs_m & (WLAST != drv_is_last);
    if (exp_bp_p || b_push) begin
      chk("b_push", b_push, exp_bp_p);
      if (b_push && eb.size() != 0) begin
        r = eb.pop_front();
        chk("b_id", b_id, r.id);
        chk("b_sel", b_sel, r.sel);
        chk("b_decerr", b_decerr, r.derr);
      end
    end
    exp_bp_p = hs_m & drv_is_last & drv_active;
    if ((S_WVALID & S_WREADY) != 2'b00) begin
      if (bq.size() != 0) begin
        eb_t = bq.pop_front();
        chk("s_wvalid", S_WVALID, eb_t.v);
        chk("s_wdata", S_WDATA, eb_t.d);
        chk("s_wstrb", S_WSTRB, eb_t.s);
        chk("s_wlast", S_WLAST, eb_t.l);
      end else chk("s_beat_spurious", S_WVALID, 0);
    end
    if (drv_active && ARESETn) begin
      if (drv_decerr) begin
        chk("decerr_swvalid", S_WVALID, 0);
        chk("decerr_wready", WREADY, 1);
      end else if (WVALID) begin
        chk("wready_mirror", WREADY, S_WREADY[drv_sel]);
      end
    end
  end

  task automatic enq(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic esel, input logic ederr);
    fq.push_back('{id: id, addr: addr, len: len});
    eb.push_back('{id: id, sel: esel, derr: ederr});
    update_front();
  endtask

  task automatic wait_pop(input string tag);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge ACLK);
      if (fifo_pop) got = 1;
    end
    if (!got) chk(tag, 0, 1);
    @(posedge ACLK); #1;
  endtask

  // Drives n_drive beats of a len+1 burst; WLAST asserted on beat wl_beat.
  task automatic drive_burst(input int len, input int n_drive, input logic sel,
                             input logic derr, input int wl_beat, output int stalls);
    bit done;
    stalls = 0;
    drv_active = 1; drv_sel = sel; drv_decerr = derr;
    for (int i = 0; i < n_drive; i++) begin
      WVALID = 1; WDATA = $urandom; WSTRB = 4'($urandom);
      WLAST = (i == wl_beat); drv_is_last = (i == len);
      if (!derr) bq.push_back('{v: (sel ? 2'b10 : 2'b01), d: WDATA, s: WSTRB, l: (i == len)});
      done = 0;
      for (int w = 0; w < 64 && !done; w++) begin
        @(negedge ACLK);
        if (WREADY) done = 1; else stalls++;
        @(posedge ACLK); #1;
      end
      if (!done) begin chk("beat_timeout", 0, 1); break; end
    end
    WVALID = 0; WLAST = 0; drv_active = 0; drv_is_last = 0;
  endtask

  task automatic wait_b(input string tag);
    for (int i = 0; i < 20 && eb.size() != 0; i++) @(negedge ACLK);
    chk(tag, eb.size(), 0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    int st, w0;
    ARESETn = 0; b_full = 0; WVALID = 0; WLAST = 0; WDATA = '0; WSTRB = '0;
    S_WREADY = 2'b11;
    update_front();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_fifo_pop", fifo_pop, 0); chk("rst_wready", WREADY, 0);
    chk("rst_s_wvalid", S_WVALID, 0); chk("rst_s_wlast", S_WLAST, 0);
    chk("rst_b_push", b_push, 0); chk("rst_b_id", b_id, 0); chk("rst_b_sel", b_sel, 0);
    chk("rst_b_decerr", b_decerr, 0); chk("rst_wlast_err", wlast_err, 0);
    @(posedge ACLK); #1; ARESETn = 1;

    // 1: single burst to slave 1, 4 beats, first beat one cycle after pop
    enq(4'h5, 32'h1000_0000, 4'd3, 1'b1, 1'b0);
    wait_pop("t1_pop_timeout");
    drive_burst(3, 4, 1'b1, 1'b0, 3, st);
    chk("t1_stalls", st, 0);
    wait_b("t1_b_drain");

    // 2: slave-0 backpressure 1,0,0,1 (bit 1 deliberately opposite)
    enq(4'h6, 32'h0000_0100, 4'd1, 1'b0, 1'b0);
    wait_pop("t2_pop_timeout");
    rdy_pat.push_back(2'b01); rdy_pat.push_back(2'b10);
    rdy_pat.push_back(2'b10); rdy_pat.push_back(2'b01);
    drive_burst(1, 2, 1'b0, 1'b0, 1, st);
    chk("t2_stalls", st, 2);
    wait_b("t2_b_drain");

    // 3: decode error sinks beats even with slaves not ready
    rdy_default = 2'b00;
    enq(4'h9, 32'h3000_0000, 4'd2, 1'b1, 1'b1);
    wait_pop("t3_pop_timeout");
    drive_burst(2, 3, 1'b1, 1'b1, 2, st);
    chk("t3_stalls", st, 0);
    wait_b("t3_b_drain");
    rdy_default = 2'b11;

    // 4: early master WLAST -> error at beats 2 and 4, burst still 4 beats
    w0 = werr_cnt;
    enq(4'hA, 32'h0000_0040, 4'd3, 1'b0, 1'b0);
    wait_pop("t4_pop_timeout");
    drive_burst(3, 4, 1'b0, 1'b0, 1, st);
    wait_b("t4_b_drain");
    chk("t4_werr_cnt", werr_cnt - w0, 2);

    // 5: b_full holds off pops; back-to-back bursts with one bubble
    b_full = 1;
    enq(4'h1, 32'h0000_0000, 4'd1, 1'b0, 1'b0);
    enq(4'h2, 32'h1000_0000, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK); chk("t5_no_pop_bfull", fifo_pop, 0);
    end
    @(posedge ACLK); #1; b_full = 0;
    wait_pop("t5_popA_timeout");
    drive_burst(1, 2, 1'b0, 1'b0, 1, st);
    @(negedge ACLK);
    chk("t5_bubble_pop", fifo_pop, 1);
    chk("t5_bubble_wready", WREADY, 0);
    @(posedge ACLK); #1;
    drive_burst(2, 3, 1'b1, 1'b0, 2, st);
    wait_b("t5_b_drain");

    // 6: reset during beat 2 of an 8-beat burst abandons it
    enq(4'h3, 32'h0000_0000, 4'd7, 1'b0, 1'b0);
    enq(4'h4, 32'h1000_0004, 4'd0, 1'b1, 1'b0);
    wait_pop("t6_pop_timeout");
    drive_burst(7, 1, 1'b0, 1'b0, 7, st);
    void'(eb.pop_front());
    ARESETn = 0; WVALID = 1; WDATA = $urandom;
    @(posedge ACLK); #1; WVALID = 0;
    @(negedge ACLK);
    chk("t6_rst_fifo_pop", fifo_pop, 0); chk("t6_rst_wready", WREADY, 0);
    chk("t6_rst_s_wvalid", S_WVALID, 0); chk("t6_rst_s_wlast", S_WLAST, 0);
    chk("t6_rst_b_push", b_push, 0); chk("t6_rst_b_id", b_id, 0);
    chk("t6_rst_b_sel", b_sel, 0); chk("t6_rst_wlast_err", wlast_err, 0);
    @(posedge ACLK); #1; ARESETn = 1;
    @(negedge ACLK);
    chk("t6_pop_after_rst", fifo_pop, 1);
    chk("t6_no_b_push", b_push, 0);
    @(posedge ACLK); #1;
    drive_burst(0, 1, 1'b1, 1'b0, 0, st);
    wait_b("t6_b_drain");

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("beats_drained", bq.size(), 0);
    chk("fifo_drained", fq.size(), 0);
    chk("pop_count", pop_cnt, 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
